// File: rtl/rotate_regs.sv
// APB-style register block for the image rotate engine: configuration registers,
// job launch/complete FSM, sticky DONE/ERR status and a level interrupt.
module rotate_regs #(
  parameter logic [31:0] ID_VALUE = 32'h524F_5401
) (
  input  logic        I_PCLK,
  input  logic        I_PRESET,
  input  logic        I_REG_WE,
  input  logic        I_REG_RE,
  input  logic [7:0]  I_REG_ADDR,
  input  logic [31:0] I_REG_WDATA,
  output logic [31:0] O_REG_RDATA,
  output logic [31:0] O_SRC_ADDR,
  output logic [31:0] O_DST_ADDR,
  output logic [15:0] O_WIDTH,
  output logic [15:0] O_HEIGHT,
  output logic [1:0]  O_DIR,
  output logic        O_START,
  input  logic        I_DONE,
  input  logic        I_ERR,
  output logic        O_BUSY,
  output logic        O_IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] src_q, dst_q;
  logic [15:0] width_q, height_q;
  logic [1:0]  dir_q;
  logic        irq_en_q;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        irq_q;
  logic [31:0] rdata_q, rdata_d;

  logic [5:0]  word;
  logic        busy, size_ok, start_req;
  logic        wr_ctrl, wr_status, wr_src, wr_dst, wr_size;
  logic        unused_ok;

  assign word      = I_REG_ADDR[7:2];
  assign unused_ok = &{1'b0, I_REG_ADDR[1:0]};

  assign wr_ctrl   = I_REG_WE && (word == 6'd0);
  assign wr_status = I_REG_WE && (word == 6'd1);
  assign wr_src    = I_REG_WE && (word == 6'd2);
  assign wr_dst    = I_REG_WE && (word == 6'd3);
  assign wr_size   = I_REG_WE && (word == 6'd4);

  assign busy      = (state_q != IDLE);
  assign size_ok   = (width_q != '0) && (height_q != '0);
  assign start_req = wr_ctrl && I_REG_WDATA[0] && !busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req && size_ok) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (I_DONE || I_ERR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // W1C clear is applied first so a coincident set event takes priority.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (wr_status && I_REG_WDATA[1]) done_d = 1'b0;
    if (wr_status && I_REG_WDATA[2]) err_d  = 1'b0;
    if ((state_q == RUN) && I_DONE) done_d = 1'b1;
    if ((state_q == RUN) && I_ERR)  err_d  = 1'b1;
    if (start_req && !size_ok)      err_d  = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (I_REG_RE) begin
      case (word)
        6'd0:    rdata_d = {28'd0, irq_en_q, dir_q, 1'b0};
        6'd1:    rdata_d = {29'd0, err_q, done_q, busy};
        6'd2:    rdata_d = {src_q, 2'b00};
        6'd3:    rdata_d = {dst_q, 2'b00};
        6'd4:    rdata_d = {height_q, width_q};
        6'd5:    rdata_d = ID_VALUE;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (I_PRESET) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      dir_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irq_q   <= irq_en_q & (done_q | err_q);
      rdata_q <= rdata_d;
      if (wr_ctrl) begin
        irq_en_q <= I_REG_WDATA[3];
        if (!busy) dir_q <= I_REG_WDATA[2:1];
      end
      if (!busy) begin
        if (wr_src) src_q <= I_REG_WDATA[31:2];
        if (wr_dst) dst_q <= I_REG_WDATA[31:2];
        if (wr_size) begin
          width_q  <= I_REG_WDATA[15:0];
          height_q <= I_REG_WDATA[31:16];
        end
      end
    end
  end

  assign O_REG_RDATA = rdata_q;
  assign O_SRC_ADDR  = {src_q, 2'b00};
  assign O_DST_ADDR  = {dst_q, 2'b00};
  assign O_WIDTH     = width_q;
  assign O_HEIGHT    = height_q;
  assign O_DIR       = dir_q;
  assign O_START     = (state_q == LAUNCH);
  assign O_BUSY      = busy;
  assign O_IRQ       = irq_q;

endmodule
